// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router.
// Stores {lfd, data} per entry and tracks packet boundaries on the read side
// so that end-of-packet is flagged without inspecting the payload.
module router_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_enb,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             pkt_end
);

   localparam int unsigned PW = AW + 1;      // pointer width, extra wrap bit
   localparam int unsigned CW = WIDTH - 1;   // packet counter width
   localparam int unsigned LW = WIDTH - 2;   // header length field width

   logic [WIDTH:0]   mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             pkt_end_q, pkt_end_d;
   logic             wr_ok, rd_ok, mem_we;
   logic [WIDTH:0]   rd_entry;
   logic [LW-1:0]    hdr_len;

   // Flags derived from the registered pointers
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   end

   // Next-state for pointers, read data and packet tracking
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;
      pkt_end_d  = 1'b0;
      wr_ok      = write_enb && !full;
      rd_ok      = read_enb && !empty;
      mem_we     = wr_ok && !soft_reset;
      rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
      hdr_len    = rd_entry[WIDTH-1:2];
      if (soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         pkt_cnt_d  = '0;
         data_out_d = '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            data_out_d = rd_entry[WIDTH-1:0];
            if (rd_entry[WIDTH]) begin
               pkt_cnt_d = CW'(hdr_len) + CW'(1);
            end else if (pkt_cnt_q != '0) begin
               pkt_cnt_d = pkt_cnt_q - CW'(1);
               pkt_end_d = (pkt_cnt_q == CW'(1));
            end
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
         pkt_end_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
         pkt_end_q  <= pkt_end_d;
      end
   end

   // Storage array, never cleared by reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
      end
   end

   assign data_out = data_out_q;
   assign pkt_end  = pkt_end_q;

endmodule
